// File: rtl/toothless_dmem_resp.sv
// Data-memory responder for the LSU req/gnt/rvalid port: word RAM with byte-enable
// stores, a fixed grant-to-rvalid latency and out-of-range error reporting.
module toothless_dmem_resp #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] { IDLE, WAIT, RESP } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic          we_q;
    logic          err_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem_q [DEPTH];

    logic [30:0]   word_off;
    logic          addr_err;
    logic          resp;
    logic          commit;

    // Subtract in 33 bits: an address below BASE_ADDR sets the top bit and so fails the bound too.
    assign word_off = 31'(({1'b0, data_addr_i} - {1'b0, BASE_ADDR}) >> 2);
    assign addr_err = (word_off >= 31'(DEPTH));

    assign resp   = (state_q == RESP);
    assign commit = resp && we_q && !err_q;

    assign data_gnt_o    = data_req_i && (state_q != WAIT);
    assign data_rvalid_o = resp;
    assign data_err_o    = resp && err_q;
    assign data_rdata_o  = (resp && !we_q && !err_q) ? mem_q[idx_q] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    // IDLE and RESP both accept; a grant in RESP chains straight into the next access.
                    if (data_gnt_o) begin
                        idx_q   <= word_off[AW-1:0];
                        we_q    <= data_we_i;
                        err_q   <= addr_err;
                        be_q    <= data_be_i;
                        wdata_q <= data_wdata_i;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: the RAM array is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_toothless_dmem_resp.sv
// Bench for toothless_dmem_resp: three instances (LATENCY 1, 3, 4) checked by a directed
// vector table, hand sequences and a transaction-level scoreboard under random traffic.
module tb_toothless_dmem_resp;
  localparam int          NI    = 3;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic        clk;
  logic        rst;
  logic        req    [NI];
  logic        gnt    [NI];
  logic [31:0] addr   [NI];
  logic        we     [NI];
  logic [3:0]  be     [NI];
  logic [31:0] wdata  [NI];
  logic        rvalid [NI];
  logic [31:0] rdata  [NI];
  logic        err    [NI];

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    toothless_dmem_resp #(
      .DEPTH    (DEPTH),
      .BASE_ADDR(BASE),
      .LATENCY  (g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .data_req_i   (req[g]),
      .data_gnt_o   (gnt[g]),
      .data_addr_i  (addr[g]),
      .data_we_i    (we[g]),
      .data_be_i    (be[g]),
      .data_wdata_i (wdata[g]),
      .data_rvalid_o(rvalid[g]),
      .data_rdata_o (rdata[g]),
      .data_err_o   (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic logic [31:0] init_val(input int i, input int w);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101) ^ (32'(w) * 32'h0001_0001);
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off < 0) || ((off / 4) >= DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction scoreboard ----------------
  typedef struct {
    int          inst;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          exp_cyc;
  } txn_t;

  txn_t        q[$];
  logic [31:0] mm [NI][DEPTH];

  // Grants are sampled late in the low phase, after the drivers have settled.
  always begin : recorder
    txn_t t;
    @(negedge clk);
    #3;
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        if (req[i] && gnt[i]) begin
          t.inst    = i;
          t.we      = we[i];
          t.addr    = addr[i];
          t.be      = be[i];
          t.wdata   = wdata[i];
          t.exp_cyc = cyc + lat_of(i);
          q.push_back(t);
        end
      end
    end
  end

  // Responses are in order and one at a time, so the model applies each access when its rvalid appears.
  always @(negedge clk) begin : monitor
    txn_t        t;
    int          w;
    logic [31:0] exp_rd;
    logic        exp_err;
    if (rst) begin
      q.delete();
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (rvalid[i]) begin
          if (q.size() == 0 || q[0].inst != i) begin
            check("unexpected_rvalid", 32'(rvalid[i]), 32'd0);
          end else begin
            t       = q.pop_front();
            exp_err = out_of_range(t.addr);
            exp_rd  = '0;
            if (!exp_err) begin
              w = int'((longint'(t.addr) - longint'(BASE)) / 4);
              if (t.we) begin
                for (int b = 0; b < 4; b++)
                  if (t.be[b]) mm[i][w][8*b +: 8] = t.wdata[8*b +: 8];
              end else begin
                exp_rd = mm[i][w];
              end
            end
            check("rsp_latency", 32'(cyc), 32'(t.exp_cyc));
            check("rsp_rdata", rdata[i], exp_rd);
            check("rsp_err", 32'(err[i]), 32'(exp_err));
          end
        end else begin
          check("idle_rdata", rdata[i], 32'd0);
          check("idle_err", 32'(err[i]), 32'd0);
        end
      end
      if (q.size() > 0 && cyc > q[0].exp_cyc) begin
        check("missing_rvalid", 32'(rvalid[q[0].inst]), 32'd1);
        void'(q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input int i, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    req[i]   = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    be[i]    = b;
    wdata[i] = d;
    #1;
    while (!gnt[i] && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) check("gnt_timeout", 32'(gnt[i]), 32'd1);
    @(posedge clk);
    #1;
    req[i] = 1'b0;
  endtask

  task automatic access(input int i, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat_obs);
    int acc;
    int n;
    issue(i, w, a, b, d);
    acc = cyc;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid[i] && n < 40);
    if (!rvalid[i]) check("rvalid_timeout", 32'(rvalid[i]), 32'd1);
    lat_obs = cyc - acc + 1;
    rd      = rdata[i];
    er      = err[i];
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic w, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] d,
                              input logic [31:0] er_d, input logic ee);
    vec_t v;
    v.name = nm; v.we = w; v.addr = a; v.be = b; v.wdata = d; v.exp_rd = er_d; v.exp_err = ee;
    return v;
  endfunction

  initial begin : main
    vec_t        vt[$];
    logic [31:0] rd;
    logic        er;
    int          lo;
    int          k;
    int          n;
    logic        g;
    logic        seen;
    logic        w;
    logic [31:0] a;
    int          r;

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset_rvalid", 32'(rvalid[i]), 32'd0);
      check("reset_rdata", rdata[i], 32'd0);
      check("reset_err", 32'(err[i]), 32'd0);
      check("reset_gnt", 32'(gnt[i]), 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < NI; i++) begin
      for (int wd = 0; wd < DEPTH; wd++)
        issue(i, 1'b1, BASE + 32'(4 * wd), 4'hF, init_val(i, wd));
      drain();
    end

    vt.push_back(mk("st_full",      1'b1, BASE + 32'd8,  4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0));
    vt.push_back(mk("ld_full",      1'b0, BASE + 32'd8,  4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0));
    vt.push_back(mk("st_word",      1'b1, BASE + 32'd4,  4'hF, 32'h1122_3344, 32'h0, 1'b0));
    vt.push_back(mk("st_byte2",     1'b1, BASE + 32'd4,  4'b0100, 32'h00AA_0000, 32'h0, 1'b0));
    vt.push_back(mk("ld_byte2",     1'b0, BASE + 32'd4,  4'hF, 32'h0,         32'h11AA_3344, 1'b0));
    vt.push_back(mk("st_word0",     1'b1, BASE,          4'hF, 32'hCAFE_F00D, 32'h0, 1'b0));
    vt.push_back(mk("ld_oor_hi",    1'b0, BASE + 32'(DEPTH * 4), 4'hF, 32'h0, 32'h0, 1'b1));
    vt.push_back(mk("ld_oor_lo",    1'b0, BASE - 32'd4,  4'hF, 32'h0,         32'h0, 1'b1));
    vt.push_back(mk("st_oor_hi",    1'b1, BASE + 32'(DEPTH * 4), 4'hF, 32'h1234_5678, 32'h0, 1'b1));
    vt.push_back(mk("ld_word0",     1'b0, BASE,          4'hF, 32'h0,         32'hCAFE_F00D, 1'b0));
    vt.push_back(mk("st_be0",       1'b1, BASE + 32'd8,  4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0));
    vt.push_back(mk("ld_be0",       1'b0, BASE + 32'd8,  4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0));
    vt.push_back(mk("st_last",      1'b1, BASE + 32'(DEPTH * 4 - 4), 4'hF, 32'hA5A5_A5A5, 32'h0, 1'b0));
    vt.push_back(mk("ld_last_be1",  1'b0, BASE + 32'(DEPTH * 4 - 4), 4'h1, 32'h0, 32'hA5A5_A5A5, 1'b0));
    vt.push_back(mk("ld_oor_wrap",  1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,         32'h0, 1'b1));
    vt.push_back(mk("ld_unaligned", 1'b0, BASE + 32'd11, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0));

    foreach (vt[j]) begin
      access(0, vt[j].we, vt[j].addr, vt[j].be, vt[j].wdata, rd, er, lo);
      check({vt[j].name, "_rdata"}, rd, vt[j].exp_rd);
      check({vt[j].name, "_err"}, 32'(er), 32'(vt[j].exp_err));
      check({vt[j].name, "_lat"}, 32'(lo), 32'd1);
    end
    drain();

    // LATENCY=3 with req held: grants land on every third cycle.
    k = 0;
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = BASE;
    for (int c = 0; c < 10; c++) begin
      #1;
      g = gnt[1];
      check("b2b_gnt", 32'(g), (c % 3 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      if (g) begin
        k++;
        addr[1] = BASE + 32'(4 * k);
      end
    end
    req[1] = 1'b0;
    drain();

    // Store immediately followed by a load of the same word.
    issue(1, 1'b1, BASE + 32'd20, 4'hF, 32'h600D_CAFE);
    access(1, 1'b0, BASE + 32'd20, 4'hF, 32'h0, rd, er, lo);
    check("raw_rdata", rd, 32'h600D_CAFE);
    check("raw_lat", 32'(lo), 32'd3);
    drain();

    // Reset while a LATENCY=4 store is still waiting.
    issue(2, 1'b1, BASE + 32'd12, 4'hF, 32'h0BAD_F00D);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | rvalid[2];
    end
    check("rst_wait_no_rvalid", 32'(seen), 32'd0);
    access(2, 1'b0, BASE + 32'd12, 4'hF, 32'h0, rd, er, lo);
    check("rst_wait_word_kept", rd, init_val(2, 3));
    check("rst_wait_lat", 32'(lo), 32'd4);
    drain();

    // Asynchronous reset in the middle of a response cycle.
    issue(2, 1'b0, BASE + 32'd16, 4'hF, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid[2] && n < 40);
    check("async_pre_rdata", rdata[2], init_val(2, 4));
    #1;
    rst = 1'b1;
    #1;
    check("async_rvalid", 32'(rvalid[2]), 32'd0);
    check("async_rdata", rdata[2], 32'd0);
    check("async_err", 32'(err[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Random traffic, one instance at a time, scored by the monitor.
    for (int i = 0; i < NI; i++) begin
      for (int t = 0; t < 120; t++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        r = int'($urandom_range(0, 9));
        if (r == 0)      a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 3));
        else if (r == 1) a = BASE - 32'(4 * $urandom_range(1, 4));
        else             a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
        w = 1'($urandom_range(0, 1));
        issue(i, w, a, 4'($urandom_range(0, 15)), $urandom);
      end
      drain();
    end

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toothless_dmem_resp.md
Name: toothless_dmem_resp

Overview:
Data-memory responder that serves the load/store requests issued by the core's LSU for OPC_LOAD and OPC_STORE instructions. The block is the memory-side end of the LSU data interface and uses a req/gnt/rvalid handshake. It holds a word-addressed RAM with byte-enable writes and a configurable response latency, and flags out-of-range accesses. In the testbench and FPGA top level it sits between the core's data port and nothing else.

Parameters:
DEPTH, 1024, number of 32-bit words in the RAM (power of two, >=2)
BASE_ADDR, 32'h0001_0000, byte address of word 0 (DEPTH*4-aligned)
LATENCY, 1, cycles from grant to rvalid (1..15)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
data_req_i  in  1  LSU request valid
data_gnt_o  out  1  request accepted this cycle (combinational from state and req)
data_addr_i  in  32  byte address; bits [1:0] ignored (LSU word-aligns)
data_we_i  in  1  1 = store, 0 = load
data_be_i  in  4  byte enables, bit i = byte lane i (little-endian)
data_wdata_i  in  32  store data, already lane-shifted by LSU
data_rvalid_o  out  1  response valid, exactly one cycle per granted request
data_rdata_o  out  32  load data (full word); 0 when rvalid low or for stores
data_err_o  out  1  access error, qualified by data_rvalid_o

Behaviour:
- Reset: all outputs 0, FSM in IDLE, latency counter 0, captured request cleared. RAM contents are not reset.
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high. Asserting rst_i mid-transaction drops the pending request: no RAM write and no rvalid.
- States: IDLE, WAIT, RESP.
- data_gnt_o = data_req_i while in IDLE or RESP, and 0 in WAIT.
- Accept: on req&gnt, capture addr, we, be and wdata. Go to RESP if LATENCY==1; otherwise go to WAIT with counter=LATENCY-2.
- WAIT: decrement the counter each cycle. At 0, go to RESP.
- RESP: drive rvalid=1 for one cycle.
  - If another request is accepted in the same cycle, follow the accept transition.
  - Otherwise go to IDLE.
  - This allows back-to-back accesses at one per LATENCY cycles.
- Latency: a request granted at edge N gives rvalid high in the cycle after edge N+LATENCY-1, so the response is sampled at edge N+LATENCY.
- Range check: index = (addr - BASE_ADDR) >> 2. The access is out of range if addr < BASE_ADDR or index >= DEPTH. Compute it in 33 bits so there is no wrap-around.
- Out-of-range access: err=1, rdata=0, no write.
- be==4'b0000 is legal. It is a no-op store or returns the full word on a load; err=0.
- Stores are committed to RAM at the end of the RESP cycle. Only lanes with be[i]=1 are written; other bytes are preserved. rdata=0.
- Loads return the RAM word read in the RESP cycle, with all 4 bytes regardless of be. Sign/zero extension is done by the LSU.
- Read-after-write ordering: a load granted in the RESP cycle of a store to the same word returns the new data, because the store commits before the load's read.
- data_rdata_o and data_err_o are 0 whenever data_rvalid_o is 0.
- Requests presented in WAIT are held off (gnt=0). The LSU must keep req, addr, we, be and wdata stable until it sees gnt.

Test Plan:
- Reset then idle: rst_i pulse mid-cycle, req=0 -> all outputs 0 immediately (asynchronous), remain 0.
- LATENCY=1, store addr=BASE_ADDR+8, be=4'hF, wdata=32'hDEADBEEF; then load same address -> gnt on request cycle, rvalid one cycle later, load rdata=32'hDEADBEEF, err=0.
- Byte store: word holds 32'h11223344; store be=4'b0100, wdata=32'h00AA0000; load -> rdata=32'h11AA3344.
- Out of range: load addr=BASE_ADDR+DEPTH*4, and a second load at BASE_ADDR-4 -> rvalid with err=1, rdata=0; a store to BASE_ADDR+DEPTH*4 leaves word 0 unchanged.
- LATENCY=3, req held high for 4 back-to-back loads -> gnt pattern 1,0,0,1,0,0,1..., each rvalid exactly 3 cycles after its grant; a store followed immediately by a load to the same word returns the stored value.
- Reset in WAIT: LATENCY=4, grant a store, assert rst_i 2 cycles later -> no rvalid, word unchanged on subsequent load.
